// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side memory subsystem for a single-cycle core.
//
// Word-addressed data RAM plus a memory-mapped peripheral window at 0xFFFF_xxxx
// containing a GPIO output register, a synchronised GPIO input, a free-running
// cycle counter and a down-counting timer with an interrupt flag. Reads are
// combinational from dmem_addr; writes commit on the rising clock edge.
//
// Optional feature: define MMIO_TIMER_RELOAD_EN to make the timer reload
// TIMER_LOAD on expiry instead of stopping at zero.
//
// Ports:
//   clk        - system clock, all state updates on rising edge
//   rst        - synchronous active-high reset (MMIO state only, RAM untouched)
//   dmem_we    - store enable from core
//   dmem_addr  - byte address from core; bits [1:0] ignored
//   dmem_wdata - store data
//   dmem_rdata - load data, combinational from dmem_addr and current state
//   gpio_in    - asynchronous external inputs
//   gpio_out   - GPIO output register
//   timer_irq  - timer interrupt level (STATUS & IE)

module dmem_mmio #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned GPIO_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dmem_we,
    input  logic [31:0]       dmem_addr,
    input  logic [31:0]       dmem_wdata,
    output logic [31:0]       dmem_rdata,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [15:0] OffGpioOut  = 16'h0000;
    localparam logic [15:0] OffGpioIn   = 16'h0004;
    localparam logic [15:0] OffCycle    = 16'h0008;
    localparam logic [15:0] OffTmrLoad  = 16'h000C;
    localparam logic [15:0] OffTmrCount = 16'h0010;
    localparam logic [15:0] OffTmrCtrl  = 16'h0014;

    // Address decode
    logic          is_mmio;
    logic          is_ram;
    logic [15:0]   offset;
    logic [AW-1:0] ram_idx;

    assign is_mmio = (dmem_addr[31:16] == 16'hFFFF);
    assign is_ram  = (dmem_addr[31:16] == 16'h0000) && ({2'b00, dmem_addr[31:2]} < DEPTH);
    assign offset  = dmem_addr[15:0];
    assign ram_idx = dmem_addr[AW+1:2];

    // Data RAM: no reset, writes proceed even while rst is high.
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (dmem_we && is_ram) begin
            mem[ram_idx] <= dmem_wdata;
        end
    end

    // MMIO state
    logic [GPIO_W-1:0] gpio_out_q;
    logic [GPIO_W-1:0] sync1_q, sync2_q;
    logic [31:0]       cycle_q;
    logic [31:0]       load_q;
    logic [31:0]       count_q, count_d;
    logic              en_q, status_q, status_d, ie_q;

    logic wr_mmio, wr_gpio, wr_cycle, wr_load, wr_ctrl;
    logic timer_expire, expire_flag;

    assign wr_mmio  = dmem_we && is_mmio;
    assign wr_gpio  = wr_mmio && (offset == OffGpioOut);
    assign wr_cycle = wr_mmio && (offset == OffCycle);
    assign wr_load  = wr_mmio && (offset == OffTmrLoad);
    assign wr_ctrl  = wr_mmio && (offset == OffTmrCtrl);

    // Expiry uses the EN value held before any CTRL write at this edge.
    assign timer_expire = en_q && (count_q == 32'd1);
    // A LOAD write overrides the countdown, so no expiry is flagged with it.
    assign expire_flag  = timer_expire && !wr_load;

    always_comb begin
        count_d = count_q;
        if (wr_load) begin
            count_d = dmem_wdata;
        end else if (en_q && (count_q != 32'd0)) begin
            count_d = count_q - 32'd1;
`ifdef MMIO_TIMER_RELOAD_EN
            if (timer_expire) begin
                count_d = load_q;
            end
`endif
        end
    end

    // Expiry beats a write-1-to-clear in the same cycle.
    always_comb begin
        status_d = status_q;
        if (expire_flag) begin
            status_d = 1'b1;
        end else if (wr_ctrl && dmem_wdata[1]) begin
            status_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            cycle_q    <= '0;
            load_q     <= '0;
            count_q    <= '0;
            en_q       <= 1'b0;
            status_q   <= 1'b0;
            ie_q       <= 1'b0;
        end else begin
            sync1_q  <= gpio_in;
            sync2_q  <= sync1_q;
            cycle_q  <= wr_cycle ? 32'd0 : cycle_q + 32'd1;
            count_q  <= count_d;
            status_q <= status_d;
            if (wr_gpio) begin
                gpio_out_q <= dmem_wdata[GPIO_W-1:0];
            end
            if (wr_load) begin
                load_q <= dmem_wdata;
            end
            if (wr_ctrl) begin
                en_q <= dmem_wdata[0];
                ie_q <= dmem_wdata[2];
            end
        end
    end

    assign gpio_out  = gpio_out_q;
    assign timer_irq = status_q & ie_q;

    // Read path
    logic [31:0] mmio_rdata;

    always_comb begin
        mmio_rdata = '0;
        case (offset)
            OffGpioOut:  mmio_rdata = 32'(gpio_out_q);
            OffGpioIn:   mmio_rdata = 32'(sync2_q);
            OffCycle:    mmio_rdata = cycle_q;
            OffTmrLoad:  mmio_rdata = load_q;
            OffTmrCount: mmio_rdata = count_q;
            OffTmrCtrl:  mmio_rdata = {29'd0, ie_q, status_q, en_q};
            default:     mmio_rdata = '0;
        endcase
    end

    always_comb begin
        dmem_rdata = '0;
        if (is_mmio) begin
            dmem_rdata = mmio_rdata;
        end else if (is_ram) begin
            dmem_rdata = mem[ram_idx];
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;

    localparam int unsigned DEPTH  = 256;
    localparam int unsigned GPIO_W = 8;
    localparam int unsigned AW     = $clog2(DEPTH);
`ifdef MMIO_TIMER_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    localparam logic [31:0] A_GPO   = 32'hFFFF_0000;
    localparam logic [31:0] A_GPI   = 32'hFFFF_0004;
    localparam logic [31:0] A_CYC   = 32'hFFFF_0008;
    localparam logic [31:0] A_LOAD  = 32'hFFFF_000C;
    localparam logic [31:0] A_COUNT = 32'hFFFF_0010;
    localparam logic [31:0] A_CTRL  = 32'hFFFF_0014;

    logic              clk = 1'b0;
    logic              rst;
    logic              dmem_we;
    logic [31:0]       dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic [GPIO_W-1:0] gpio_in;
    logic [GPIO_W-1:0] gpio_out;
    logic              timer_irq;

    int total = 0;
    int bad   = 0;

    dmem_mmio #(.DEPTH(DEPTH), .GPIO_W(GPIO_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .timer_irq  (timer_irq)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register values and pin history.
    logic [31:0]       m_mem [DEPTH];
    bit                m_valid [DEPTH];
    logic [GPIO_W-1:0] m_gpio;
    logic [GPIO_W-1:0] m_pins [$];
    logic [31:0]       m_cycle, m_load, m_count;
    bit                m_en, m_status, m_ie;

    function automatic bit m_is_ram(input logic [31:0] a);
        return (a[31:16] == 16'h0000) && ({2'b00, a[31:2]} < 32'(DEPTH));
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:16] == 16'hFFFF) begin
            case (a[15:0])
                16'h0000: return 32'(m_gpio);
                16'h0004: return 32'(m_pins[0]);
                16'h0008: return m_cycle;
                16'h000C: return m_load;
                16'h0010: return m_count;
                16'h0014: return {29'd0, m_ie, m_status, m_en};
                default:  return 32'd0;
            endcase
        end
        if (m_is_ram(a)) return m_mem[a[AW+1:2]];
        return 32'd0;
    endfunction

    function automatic bit model_known(input logic [31:0] a);
        if (m_is_ram(a)) return m_valid[a[AW+1:2]];
        return 1'b1;
    endfunction

    // Applies the inputs present just before a rising edge to the model.
    task automatic model_edge();
        bit          mw;
        bit          ld, cw, expire;
        logic [15:0] off;
        logic [31:0] nc;
        off = dmem_addr[15:0];
        mw  = dmem_we && (dmem_addr[31:16] == 16'hFFFF);
        if (dmem_we && m_is_ram(dmem_addr)) begin
            m_mem[dmem_addr[AW+1:2]]   = dmem_wdata;
            m_valid[dmem_addr[AW+1:2]] = 1'b1;
        end
        if (rst) begin
            m_gpio = '0; m_cycle = 0; m_load = 0; m_count = 0;
            m_en = 0; m_status = 0; m_ie = 0;
            m_pins = {};
            m_pins.push_back('0);
            m_pins.push_back('0);
            return;
        end
        ld     = mw && (off == 16'h000C);
        cw     = mw && (off == 16'h0014);
        expire = m_en && (m_count == 1) && !ld;
        if (ld)                           nc = dmem_wdata;
        else if (!m_en || m_count == 0)   nc = m_count;
        else if (m_count == 1)            nc = RELOAD ? m_load : 32'd0;
        else                              nc = m_count - 1;
        if (expire)                       m_status = 1'b1;
        else if (cw && dmem_wdata[1])     m_status = 1'b0;
        if (cw) begin
            m_en = dmem_wdata[0];
            m_ie = dmem_wdata[2];
        end
        if (ld) m_load = dmem_wdata;
        m_count = nc;
        if (mw && off == 16'h0000) m_gpio = dmem_wdata[GPIO_W-1:0];
        m_cycle = (mw && off == 16'h0008) ? 32'd0 : m_cycle + 1;
        m_pins.push_back(gpio_in);
        void'(m_pins.pop_front());
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        dmem_we    = we;
        dmem_addr  = a;
        dmem_wdata = d;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        drive(1'b0, 32'd0, 32'd0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] offs [6];
        offs = '{A_GPO, A_GPI, A_CYC, A_LOAD, A_COUNT, A_CTRL};
        if (gpio_out !== '0) begin
            bad++; $display("FAIL reset_gpio_out got=%h want=0", gpio_out);
        end
        total++;
        if (timer_irq !== 1'b0) begin
            bad++; $display("FAIL reset_irq got=%b want=0", timer_irq);
        end
        total++;
        foreach (offs[i]) begin
            drive(1'b0, offs[i], 32'd0);
            #1;
            if (dmem_rdata !== 32'd0) begin
                bad++; $display("FAIL reset_reg_%h got=%h want=0", offs[i], dmem_rdata);
            end
            total++;
        end
    endtask

    task automatic test_ram();
        drive(1'b1, 32'h10, 32'hDEADBEEF);
        tick();
        drive(1'b0, 32'h10, 32'd0);
        #1;
        if (dmem_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL ram_read got=%h want=deadbeef", dmem_rdata);
        end
        total++;
        drive(1'b1, 32'h10, 32'h1);
        #1;
        if (dmem_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL ram_rw_same_cycle got=%h want=deadbeef", dmem_rdata);
        end
        total++;
        tick();
        drive(1'b0, 32'h10, 32'd0);
        #1;
        if (dmem_rdata !== 32'h1) begin
            bad++; $display("FAIL ram_after_write got=%h want=1", dmem_rdata);
        end
        total++;
        drive(1'b0, 32'(DEPTH) * 4, 32'd0);
        #1;
        if (dmem_rdata !== 32'd0) begin
            bad++; $display("FAIL ram_out_of_range got=%h want=0", dmem_rdata);
        end
        total++;
    endtask

    task automatic test_gpio();
        drive(1'b1, A_GPO, 32'hFFFFFFA5);
        tick();
        drive(1'b0, A_GPO, 32'd0);
        #1;
        if (gpio_out !== 8'hA5) begin
            bad++; $display("FAIL gpio_out got=%h want=a5", gpio_out);
        end
        total++;
        if (dmem_rdata !== 32'h000000A5) begin
            bad++; $display("FAIL gpio_out_readback got=%h want=000000a5", dmem_rdata);
        end
        total++;
        gpio_in = 8'h00;
        tick();
        tick();
        gpio_in = 8'h3C;
        drive(1'b0, A_GPI, 32'd0);
        tick();
        if (dmem_rdata !== 32'h0) begin
            bad++; $display("FAIL gpio_in_edge1 got=%h want=0", dmem_rdata);
        end
        total++;
        tick();
        if (dmem_rdata !== 32'h3C) begin
            bad++; $display("FAIL gpio_in_edge2 got=%h want=3c", dmem_rdata);
        end
        total++;
    endtask

    task automatic test_cycle();
        rst_pulse();
        drive(1'b0, A_CYC, 32'd0);
        repeat (10) tick();
        if (dmem_rdata !== 32'd10) begin
            bad++; $display("FAIL cycle_count got=%0d want=10", dmem_rdata);
        end
        total++;
        drive(1'b1, A_CYC, 32'h1234);
        tick();
        drive(1'b0, A_CYC, 32'd0);
        #1;
        if (dmem_rdata !== 32'd0) begin
            bad++; $display("FAIL cycle_clear got=%0d want=0", dmem_rdata);
        end
        total++;
        tick();
        if (dmem_rdata !== 32'd1) begin
            bad++; $display("FAIL cycle_after_clear got=%0d want=1", dmem_rdata);
        end
        total++;
    endtask

    task automatic test_timer_oneshot();
        logic [31:0] expc [4];
        expc = '{32'd3, 32'd2, 32'd1, RELOAD ? 32'd3 : 32'd0};
        rst_pulse();
        drive(1'b1, A_LOAD, 32'd3);
        tick();
        drive(1'b1, A_CTRL, 32'h5);
        tick();
        drive(1'b0, A_COUNT, 32'd0);
        for (int k = 0; k < 4; k++) begin
            #1;
            if (dmem_rdata !== expc[k]) begin
                bad++; $display("FAIL timer_count_%0d got=%0d want=%0d", k, dmem_rdata, expc[k]);
            end
            total++;
            if (timer_irq !== (k == 3)) begin
                bad++; $display("FAIL timer_irq_%0d got=%b want=%b", k, timer_irq, k == 3);
            end
            total++;
            if (k < 3) tick();
        end
        drive(1'b0, A_CTRL, 32'd0);
        #1;
        if (dmem_rdata !== 32'h7) begin
            bad++; $display("FAIL timer_ctrl_status got=%h want=7", dmem_rdata);
        end
        total++;
        drive(1'b1, A_CTRL, 32'h7);
        tick();
        drive(1'b0, A_CTRL, 32'd0);
        #1;
        if (timer_irq !== 1'b0) begin
            bad++; $display("FAIL timer_w1c got=%b want=0", timer_irq);
        end
        total++;
        // Set up a clear write on the exact cycle the count goes 1 -> expiry.
        drive(1'b1, A_LOAD, 32'd2);
        tick();
        drive(1'b0, A_COUNT, 32'd0);
        tick();
        drive(1'b1, A_CTRL, 32'h7);
        tick();
        drive(1'b0, A_CTRL, 32'd0);
        #1;
        if (timer_irq !== 1'b1) begin
            bad++; $display("FAIL timer_clear_vs_expiry_irq got=%b want=1", timer_irq);
        end
        total++;
        if (dmem_rdata[1] !== 1'b1) begin
            bad++; $display("FAIL timer_clear_vs_expiry_status got=%b want=1", dmem_rdata[1]);
        end
        total++;
    endtask

    task automatic test_timer_reload();
        logic [31:0] exp_r [5];
        logic [31:0] exp_o [5];
        exp_r = '{32'd2, 32'd1, 32'd2, 32'd1, 32'd2};
        exp_o = '{32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
        rst_pulse();
        drive(1'b1, A_LOAD, 32'd2);
        tick();
        drive(1'b1, A_CTRL, 32'h1);
        tick();
        drive(1'b0, A_COUNT, 32'd0);
        for (int k = 0; k < 5; k++) begin
            #1;
            if (dmem_rdata !== (RELOAD ? exp_r[k] : exp_o[k])) begin
                bad++; $display("FAIL reload_count_%0d got=%0d want=%0d", k, dmem_rdata,
                                RELOAD ? exp_r[k] : exp_o[k]);
            end
            total++;
            if (k < 4) tick();
        end
        drive(1'b0, A_CTRL, 32'd0);
        #1;
        if (dmem_rdata !== 32'h3) begin
            bad++; $display("FAIL reload_ctrl got=%h want=3", dmem_rdata);
        end
        total++;
    endtask

    task automatic test_reset_midrun();
        logic [31:0] regs [3];
        regs = '{A_LOAD, A_COUNT, A_CTRL};
        rst_pulse();
        drive(1'b1, 32'h20, 32'h12345678);
        tick();
        drive(1'b1, A_GPO, 32'h5A);
        tick();
        drive(1'b1, A_LOAD, 32'd1);
        tick();
        drive(1'b1, A_CTRL, 32'h5);
        tick();
        drive(1'b0, A_COUNT, 32'd0);
        tick();
        if (timer_irq !== 1'b1) begin
            bad++; $display("FAIL midrun_irq_before got=%b want=1", timer_irq);
        end
        total++;
        rst = 1'b1;
        drive(1'b1, 32'h24, 32'hCAFEF00D);
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h20, 32'd0);
        #1;
        if (dmem_rdata !== 32'h12345678) begin
            bad++; $display("FAIL midrun_ram_kept got=%h want=12345678", dmem_rdata);
        end
        total++;
        drive(1'b0, 32'h24, 32'd0);
        #1;
        if (dmem_rdata !== 32'hCAFEF00D) begin
            bad++; $display("FAIL midrun_ram_write_in_rst got=%h want=cafef00d", dmem_rdata);
        end
        total++;
        if (gpio_out !== '0 || timer_irq !== 1'b0) begin
            bad++; $display("FAIL midrun_outputs got=%h/%b want=0/0", gpio_out, timer_irq);
        end
        total++;
        foreach (regs[i]) begin
            drive(1'b0, regs[i], 32'd0);
            #1;
            if (dmem_rdata !== 32'd0) begin
                bad++; $display("FAIL midrun_reg_%h got=%h want=0", regs[i], dmem_rdata);
            end
            total++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            int          sel;
            rst     = ($urandom_range(0, 79) == 0);
            gpio_in = GPIO_W'($urandom);
            sel     = int'($urandom_range(0, 9));
            if (sel < 4)       a = ($urandom_range(0, 4) == 0) ? (32'(DEPTH) - 1) * 4
                                                               : 32'($urandom_range(0, 15)) * 4;
            else if (sel < 8)  a = 32'hFFFF_0000 + 32'($urandom_range(0, 6)) * 4;
            else if (sel == 8) a = ($urandom_range(0, 1) == 1) ? 32'(DEPTH) * 4
                                                               : 32'h0001_0000 + ($urandom & 32'hFFFC);
            else               a = 32'hFFFF_0100;
            d = $urandom;
            if (a == A_LOAD) d = 32'($urandom_range(0, 6));
            drive(1'($urandom_range(0, 2) == 0), a, d);
            #1;
            if (model_known(a)) begin
                if (dmem_rdata !== model_read(a)) begin
                    bad++; $display("FAIL rand_read_%0d addr=%h got=%h want=%h", i, a, dmem_rdata,
                                    model_read(a));
                end
                total++;
            end
            if (gpio_out !== m_gpio) begin
                bad++; $display("FAIL rand_gpio_%0d got=%h want=%h", i, gpio_out, m_gpio);
            end
            total++;
            if (timer_irq !== (m_status & m_ie)) begin
                bad++; $display("FAIL rand_irq_%0d got=%b want=%b", i, timer_irq, m_status & m_ie);
            end
            total++;
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        gpio_in = '0;
        drive(1'b0, 32'd0, 32'd0);
        m_pins  = {};
        m_pins.push_back('0);
        m_pins.push_back('0);
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_ram();
        test_gpio();
        test_cycle();
        test_timer_oneshot();
        test_timer_reload();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
Data-side memory subsystem directly downstream of the single-cycle core's dmem port; consumes dmem_we/dmem_addr/dmem_wdata and returns dmem_rdata in the same cycle.
- Contains a word-addressed data RAM.
- Contains a memory-mapped peripheral window with a GPIO out register, a synchronised GPIO in, a free-running cycle counter and a down-counting timer with interrupt flag.
- The core cannot stall: reads are combinational and writes commit on the clock edge.

Parameters:
DEPTH, 256, data RAM depth in 32-bit words; power of two, 16..4096
GPIO_W, 8, width of gpio_out and gpio_in

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
dmem_we  input  1  write enable from core, sampled at rising clk
dmem_addr  input  32  byte address from core ALU result; bits [1:0] ignored
dmem_wdata  input  32  store data from core
dmem_rdata  output  32  load data, combinational from dmem_addr
gpio_in  input  GPIO_W  asynchronous external inputs
gpio_out  output  GPIO_W  GPIO output register
timer_irq  output  1  timer interrupt level

Behaviour:
- Decode: MMIO when dmem_addr[31:16]==16'hFFFF. RAM when dmem_addr[31:16]==0 and word index dmem_addr[31:2] < DEPTH. Anything else is unmapped: reads 0, writes ignored.
- RAM: write mem[addr[log2(DEPTH)+1:2]] <= dmem_wdata on the clk edge when dmem_we. Read is combinational. A read and write to the same word in the same cycle returns old data. RAM is not cleared by rst.
- MMIO offsets (dmem_addr[15:0]); undefined offsets read 0 and ignore writes:
  - 0x00 GPIO_OUT: RW, low GPIO_W bits, upper read bits 0.
  - 0x04 GPIO_IN: RO. Two-flop synchroniser, so read value lags the pin by 2 cycles.
  - 0x08 CYCLE: RO count, +1 every cycle, wraps 0xFFFFFFFF->0. Any write clears it to 0 at that edge (write wins over increment).
  - 0x0C TIMER_LOAD: RW 32-bit. A write also loads TIMER_COUNT with wdata at the same edge.
  - 0x10 TIMER_COUNT: RO.
  - 0x14 TIMER_CTRL: bit0 EN (RW), bit1 STATUS (sticky; write 1 clears), bit2 IE (RW). Other bits read 0.
- Timer, each cycle with EN=1:
  - COUNT>1: COUNT-1.
  - COUNT==1: COUNT becomes 0 and STATUS sets (expiry).
  - COUNT==0: holds and does not set STATUS.
  - EN=0: COUNT holds.
- Simultaneous timer events:
  - LOAD write beats decrement/expiry in the same cycle; no expiry is flagged that cycle.
  - Expiry beats a STATUS clear write in the same cycle; STATUS stays 1.
  - CTRL write with EN and expiry in the same cycle: EN takes wdata[0]; expiry still evaluated with the old EN.
- timer_irq = STATUS & IE, registered-state derived, no extra latency.
- Reset values (rst high at edge): gpio_out=0, sync flops=0, CYCLE=0, TIMER_LOAD=0, TIMER_COUNT=0, EN=0, STATUS=0, IE=0, timer_irq=0. dmem_rdata follows decode of current state (MMIO regs read 0).
- Reset mid-operation: all MMIO state returns to reset values at the next edge regardless of dmem_we. RAM write with dmem_we during rst is still performed.

Optional Feature:
MMIO_TIMER_RELOAD_EN
- Defined: on expiry (COUNT==1, EN=1), COUNT reloads TIMER_LOAD instead of 0 and STATUS sets. With TIMER_LOAD==0, behaves as one-shot (COUNT goes to 0).
- Undefined: one-shot only as above; no reload logic synthesised.

Test Plan:
- RAM: write 0xDEADBEEF to 0x00000010, then read 0x00000010 -> 0xDEADBEEF. Read 0x00000010 in the same cycle as a write of 0x1 -> old 0xDEADBEEF. Read addr DEPTH*4 -> 0.
- GPIO: write 0xFFFFFFA5 to 0xFFFF0000 -> gpio_out=0xA5, readback 0x000000A5. Drive gpio_in=0x3C -> 0xFFFF0004 reads 0x3C on the 2nd edge after the change, not before.
- CYCLE: 10 cycles after rst release reads 10. Write to 0xFFFF0008 -> reads 1 one cycle later. Force to 0xFFFFFFFF via 2^32 run or backdoor -> wraps to 0.
- Timer one-shot: LOAD=3, CTRL=0x5 -> COUNT 3,2,1,0; STATUS=1 and timer_irq=1 on the edge COUNT hits 0. Write CTRL=0x7 (W1C) -> irq low next cycle. Clear write coinciding with expiry -> STATUS stays 1.
- Reload (MMIO_TIMER_RELOAD_EN): LOAD=2, EN=1 -> COUNT 2,1,2,1... with STATUS set on each expiry. Without the macro -> COUNT stays 0 after first expiry.
- Reset mid-run: timer counting with irq high, assert rst one cycle -> COUNT, LOAD, CTRL, gpio_out, timer_irq all 0. Previously written RAM word still reads its value.
